// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, captured into
// a main output register with a one-entry skid register behind it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is the inverse of the skid-occupied flop, so it never depends
// combinationally on out_ready. out_valid/out_* hold steady until out_ready.
package decode_stage_pkg;

  typedef enum logic [5:0] {
    INSTR_ILLEGAL = 6'd0,
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU, INSTR_XOR,
    INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK
  } rv32i_instr_e;

  typedef struct packed {
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  imm;
    logic         rd_write_en;
    logic         uses_rs1;
    logic         uses_rs2;
    rv32i_instr_e instr_type;
    logic         is_m;
    logic [2:0]   m_funct3;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, rd_write_en: 1'b0,
    uses_rs1: 1'b0, uses_rs2: 1'b0, instr_type: INSTR_ILLEGAL,
    is_m: 1'b0, m_funct3: 3'd0
  };

endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int EN_M         = 0,
  parameter int RD0_SUPPRESS = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic             out_rd_write_en,
  output logic             out_uses_rs1,
  output logic             out_uses_rs2,
  output rv32i_instr_e     out_instr_type,
  output logic             out_is_m,
  output logic [2:0]       out_m_funct3,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_accepted,
  output logic [CNT_W-1:0] cnt_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;
  bundle_t     dec;

  bundle_t         main_q, skid_q;
  logic [XLEN-1:0] main_pc_q, skid_pc_q;
  logic            out_valid_q, skid_valid_q;
  logic            accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_sh = {27'd0, in_instr[24:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'd0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

  // Decode the raw instruction word into a bundle; anything unrecognised stays illegal.
  always_comb begin
    dec     = BUNDLE_RST;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    case (opcode)
      7'b0110111: begin
        dec.instr_type  = INSTR_LUI;
        dec.imm         = imm_u;
        dec.rd_write_en = 1'b1;
      end
      7'b0010111: begin
        dec.instr_type  = INSTR_AUIPC;
        dec.imm         = imm_u;
        dec.rd_write_en = 1'b1;
      end
      7'b1101111: begin
        dec.instr_type  = INSTR_JAL;
        dec.imm         = imm_j;
        dec.rd_write_en = 1'b1;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          dec.instr_type  = INSTR_JALR;
          dec.imm         = imm_i;
          dec.rd_write_en = 1'b1;
          dec.uses_rs1    = 1'b1;
        end
      end
      7'b1100011: begin
        case (funct3)
          3'b000:  dec.instr_type = INSTR_BEQ;
          3'b001:  dec.instr_type = INSTR_BNE;
          3'b100:  dec.instr_type = INSTR_BLT;
          3'b101:  dec.instr_type = INSTR_BGE;
          3'b110:  dec.instr_type = INSTR_BLTU;
          3'b111:  dec.instr_type = INSTR_BGEU;
          default: dec.instr_type = INSTR_ILLEGAL;
        endcase
        dec.imm      = imm_b;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      7'b0000011: begin
        case (funct3)
          3'b000:  dec.instr_type = INSTR_LB;
          3'b001:  dec.instr_type = INSTR_LH;
          3'b010:  dec.instr_type = INSTR_LW;
          3'b100:  dec.instr_type = INSTR_LBU;
          3'b101:  dec.instr_type = INSTR_LHU;
          default: dec.instr_type = INSTR_ILLEGAL;
        endcase
        dec.imm         = imm_i;
        dec.rd_write_en = 1'b1;
        dec.uses_rs1    = 1'b1;
      end
      7'b0100011: begin
        case (funct3)
          3'b000:  dec.instr_type = INSTR_SB;
          3'b001:  dec.instr_type = INSTR_SH;
          3'b010:  dec.instr_type = INSTR_SW;
          default: dec.instr_type = INSTR_ILLEGAL;
        endcase
        dec.imm      = imm_s;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      7'b0010011: begin
        dec.imm = imm_i;
        case (funct3)
          3'b000: dec.instr_type = INSTR_ADDI;
          3'b010: dec.instr_type = INSTR_SLTI;
          3'b011: dec.instr_type = INSTR_SLTIU;
          3'b100: dec.instr_type = INSTR_XORI;
          3'b110: dec.instr_type = INSTR_ORI;
          3'b111: dec.instr_type = INSTR_ANDI;
          3'b001: begin
            dec.imm = imm_sh;
            if (funct7 == 7'b0000000) dec.instr_type = INSTR_SLLI;
          end
          default: begin
            dec.imm = imm_sh;
            if (funct7 == 7'b0000000)      dec.instr_type = INSTR_SRLI;
            else if (funct7 == 7'b0100000) dec.instr_type = INSTR_SRAI;
          end
        endcase
        dec.rd_write_en = 1'b1;
        dec.uses_rs1    = 1'b1;
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.instr_type = INSTR_ADD;
            3'b001:  dec.instr_type = INSTR_SLL;
            3'b010:  dec.instr_type = INSTR_SLT;
            3'b011:  dec.instr_type = INSTR_SLTU;
            3'b100:  dec.instr_type = INSTR_XOR;
            3'b101:  dec.instr_type = INSTR_SRL;
            3'b110:  dec.instr_type = INSTR_OR;
            default: dec.instr_type = INSTR_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec.instr_type = INSTR_SUB;
          else if (funct3 == 3'b101) dec.instr_type = INSTR_SRA;
        end else if ((EN_M != 0) && (funct7 == 7'b0000001)) begin
          // M ops ride on the ADD slot; execute selects the unit by is_m/m_funct3.
          dec.instr_type = INSTR_ADD;
          dec.is_m       = 1'b1;
          dec.m_funct3   = funct3;
        end
        dec.rd_write_en = 1'b1;
        dec.uses_rs1    = 1'b1;
        dec.uses_rs2    = 1'b1;
      end
      7'b0001111: begin
        if (funct3 == 3'b000) dec.instr_type = INSTR_FENCE;
      end
      7'b1110011: begin
        if (in_instr == 32'h0000_0073)      dec.instr_type = INSTR_ECALL;
        else if (in_instr == 32'h0010_0073) dec.instr_type = INSTR_EBREAK;
      end
      default: dec.instr_type = INSTR_ILLEGAL;
    endcase
    // Illegal words carry only their raw register fields.
    if (dec.instr_type == INSTR_ILLEGAL) begin
      dec.imm         = 32'd0;
      dec.rd_write_en = 1'b0;
      dec.uses_rs1    = 1'b0;
      dec.uses_rs2    = 1'b0;
      dec.is_m        = 1'b0;
      dec.m_funct3    = 3'd0;
    end
    if ((RD0_SUPPRESS != 0) && (dec.rd == 5'd0)) dec.rd_write_en = 1'b0;
  end

  // Flush wins over any same-cycle input; in_ready only reflects the skid flop.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q && !flush;

  // Main register: refill from skid first (older), else from input, when empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      main_q      <= BUNDLE_RST;
      main_pc_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_q      <= skid_q;
        main_pc_q   <= skid_pc_q;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        main_q      <= dec;
        main_pc_q   <= in_pc;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Skid register: catches an accept while main is stalled, empties when main drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_q       <= BUNDLE_RST;
      skid_pc_q    <= '0;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if (out_valid_q && out_ready) begin
      skid_valid_q <= 1'b0;
    end else if (out_valid_q && accept) begin
      skid_q       <= dec;
      skid_pc_q    <= in_pc;
      skid_valid_q <= 1'b1;
    end
  end

  // Saturating counters of accepted and accepted-illegal words; flush does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_accepted <= '0;
      cnt_illegal  <= '0;
    end else if (accept) begin
      if (cnt_accepted != {CNT_W{1'b1}}) cnt_accepted <= cnt_accepted + CNT_W'(1);
      if ((dec.instr_type == INSTR_ILLEGAL) && (cnt_illegal != {CNT_W{1'b1}}))
        cnt_illegal <= cnt_illegal + CNT_W'(1);
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = main_pc_q;
  assign out_rs1         = main_q.rs1;
  assign out_rs2         = main_q.rs2;
  assign out_rd          = main_q.rd;
  assign out_imm         = main_q.imm;
  assign out_rd_write_en = main_q.rd_write_en;
  assign out_uses_rs1    = main_q.uses_rs1;
  assign out_uses_rs2    = main_q.uses_rs2;
  assign out_instr_type  = main_q.instr_type;
  assign out_is_m        = main_q.is_m;
  assign out_m_funct3    = main_q.m_funct3;
  assign out_illegal     = (main_q.instr_type == INSTR_ILLEGAL);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M extension on / off) share one
// stimulus stream; expected bundles are queued on accept and popped by
// per-instance monitors whenever an output transfer happens.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int W     = 93;
  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0]  instr;
    rv32i_instr_e typ;
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  imm;
    logic         wen, u1, u2, is_m;
    logic [2:0]   mf3;
  } vec_t;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic             m_in_ready, m_out_valid, m_wen, m_u1, m_u2, m_is_m, m_ill;
  logic [31:0]      m_pc, m_imm;
  logic [4:0]       m_rs1, m_rs2, m_rd;
  logic [2:0]       m_mf3;
  rv32i_instr_e     m_type;
  logic [CNT_W-1:0] m_cnt_acc, m_cnt_ill;

  logic             n_in_ready, n_out_valid, n_wen, n_u1, n_u2, n_is_m, n_ill;
  logic [31:0]      n_pc, n_imm;
  logic [4:0]       n_rs1, n_rs2, n_rd;
  logic [2:0]       n_mf3;
  rv32i_instr_e     n_type;
  logic [CNT_W-1:0] n_cnt_acc, n_cnt_ill;

  logic [W-1:0] exp_m_q[$];
  logic [W-1:0] exp_n_q[$];
  vec_t         vecs[12];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_acc = 0, exp_ill_m = 0, exp_ill_n = 0;
  logic [31:0]  pc_cnt = 32'h0000_0100;

  decode_stage #(.XLEN(32), .EN_M(1), .RD0_SUPPRESS(1), .CNT_W(CNT_W)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_pc), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_rd(m_rd), .out_imm(m_imm),
    .out_rd_write_en(m_wen), .out_uses_rs1(m_u1), .out_uses_rs2(m_u2),
    .out_instr_type(m_type), .out_is_m(m_is_m), .out_m_funct3(m_mf3),
    .out_illegal(m_ill), .cnt_accepted(m_cnt_acc), .cnt_illegal(m_cnt_ill)
  );

  decode_stage #(.XLEN(32), .EN_M(0), .RD0_SUPPRESS(1), .CNT_W(CNT_W)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_pc), .out_rs1(n_rs1), .out_rs2(n_rs2), .out_rd(n_rd), .out_imm(n_imm),
    .out_rd_write_en(n_wen), .out_uses_rs1(n_u1), .out_uses_rs2(n_u2),
    .out_instr_type(n_type), .out_is_m(n_is_m), .out_m_funct3(n_mf3),
    .out_illegal(n_ill), .cnt_accepted(n_cnt_acc), .cnt_illegal(n_cnt_ill)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input vec_t v, input logic [31:0] pc, input bit no_m);
    if ((v.typ == INSTR_ILLEGAL) || (no_m && v.is_m))
      return {pc, v.rs1, v.rs2, v.rd, 32'd0, 3'b000, 6'(INSTR_ILLEGAL), 1'b0, 3'd0, 1'b1};
    return {pc, v.rs1, v.rs2, v.rd, v.imm, v.wen, v.u1, v.u2, 6'(v.typ), v.is_m, v.mf3, 1'b0};
  endfunction

  function automatic int sat_inc(input int c);
    return (c == (1 << CNT_W) - 1) ? c : c + 1;
  endfunction

  // Scoreboard monitors: one per instance, pop on every output transfer
  always @(negedge clk) begin
    if (rst_n && m_out_valid && out_ready) begin
      if (exp_m_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL m_unexpected: got pc %h expected no output", m_pc);
      end else begin
        chk("m_bundle", {m_pc, m_rs1, m_rs2, m_rd, m_imm, m_wen, m_u1, m_u2, 6'(m_type),
                         m_is_m, m_mf3, m_ill}, exp_m_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && n_out_valid && out_ready) begin
      if (exp_n_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL n_unexpected: got pc %h expected no output", n_pc);
      end else begin
        chk("n_bundle", {n_pc, n_rs1, n_rs2, n_rd, n_imm, n_wen, n_u1, n_u2, 6'(n_type),
                         n_is_m, n_mf3, n_ill}, exp_n_q.pop_front());
      end
    end
  end

  // Driver: present one vector and hold it until accepted; queue expectations on accept
  task automatic send(input int idx);
    int  waited = 0;
    bit  done   = 0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = pc_cnt;
    while (!done) begin
      @(negedge clk);
      if (m_in_ready && !flush) begin
        exp_m_q.push_back(pack_exp(vecs[idx], pc_cnt, 1'b0));
        exp_n_q.push_back(pack_exp(vecs[idx], pc_cnt, 1'b1));
        exp_acc = sat_inc(exp_acc);
        if (vecs[idx].typ == INSTR_ILLEGAL) exp_ill_m = sat_inc(exp_ill_m);
        if (vecs[idx].typ == INSTR_ILLEGAL || vecs[idx].is_m) exp_ill_n = sat_inc(exp_ill_n);
        pc_cnt = pc_cnt + 32'd4;
        done   = 1;
      end else if (waited > 200) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: got in_ready low expected accept of vector %0d", idx);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    out_ready = 1'b1;
    while ((exp_m_q.size() != 0 || exp_n_q.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", W'(exp_m_q.size() + exp_n_q.size()), W'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_acc_m"}, W'(m_cnt_acc), W'(exp_acc));
    chk({tag, "_acc_n"}, W'(n_cnt_acc), W'(exp_acc));
    chk({tag, "_ill_m"}, W'(m_cnt_ill), W'(exp_ill_m));
    chk({tag, "_ill_n"}, W'(n_cnt_ill), W'(exp_ill_n));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"},  W'({m_out_valid, n_out_valid}), W'(0));
    chk({tag, "_ready"},  W'({m_in_ready, n_in_ready}), W'(3));
    chk({tag, "_pay_m"},  {m_pc, m_rs1, m_rs2, m_rd, m_imm, m_wen, m_u1, m_u2, 6'(m_type),
                           m_is_m, m_mf3, 1'b0},
                          {32'd0, 15'd0, 32'd0, 3'b000, 6'(INSTR_ILLEGAL), 1'b0, 3'd0, 1'b0});
    chk({tag, "_type_n"}, W'(n_type), W'(INSTR_ILLEGAL));
    chk({tag, "_cnt"},    W'({m_cnt_acc, m_cnt_ill, n_cnt_acc, n_cnt_ill}), W'(0));
  endtask

  // Main stimulus sequence
  initial begin
    logic [7:0] pat;
    //            instr          type           rs1    rs2    rd     imm            wen   u1    u2    is_m  mf3
    vecs[0]  = '{32'h00500093, INSTR_ADDI,    5'd0,  5'd5,  5'd1,  32'd5,         1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{32'h4030D113, INSTR_SRAI,    5'd1,  5'd3,  5'd2,  32'd3,         1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{32'h0020F1B3, INSTR_AND,     5'd1,  5'd2,  5'd3,  32'd0,         1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[3]  = '{32'h022081B3, INSTR_ADD,     5'd1,  5'd2,  5'd3,  32'd0,         1'b1, 1'b1, 1'b1, 1'b1, 3'd0};
    vecs[4]  = '{32'h00000013, INSTR_ADDI,    5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[5]  = '{32'h0020A423, INSTR_SW,      5'd1,  5'd2,  5'd8,  32'd8,         1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[6]  = '{32'hFE208EE3, INSTR_BEQ,     5'd1,  5'd2,  5'd29, 32'hFFFFFFFC,  1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[7]  = '{32'h123452B7, INSTR_LUI,     5'd8,  5'd3,  5'd5,  32'h12345000,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{32'h008000EF, INSTR_JAL,     5'd0,  5'd8,  5'd1,  32'd8,         1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{32'h00000000, INSTR_ILLEGAL, 5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{32'hFFF12303, INSTR_LW,      5'd2,  5'd31, 5'd6,  32'hFFFFFFFF,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{32'h40009093, INSTR_ILLEGAL, 5'd1,  5'd0,  5'd1,  32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single addi: one-cycle latency
    out_ready = 1'b1;
    send(0);
    @(negedge clk);
    chk("lat1_valid", W'({m_out_valid, n_out_valid}), W'(3));
    wait_drain();

    // srai, and, mul back to back
    send(1);
    send(2);
    send(3);
    wait_drain();
    check_counters("t3");

    // Stall: A in main, B in skid, C held until out_ready returns
    out_ready = 1'b0;
    send(0);
    send(1);
    @(negedge clk);
    chk("skid_full_ready", W'({m_in_ready, n_in_ready}), W'(0));
    chk("skid_full_valid", W'({m_out_valid, n_out_valid}), W'(3));
    @(posedge clk); #1;
    fork
      send(2);
      begin
        repeat (3) @(negedge clk);
        chk("held_cnt", W'(m_cnt_acc), W'(exp_acc));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with both registers full and a word on the input
    out_ready = 1'b0;
    send(0);
    send(1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = vecs[5].instr;
    in_pc    = 32'hDEAD_0000;
    @(negedge clk);
    exp_m_q.delete();
    exp_n_q.delete();
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", W'({m_out_valid, n_out_valid}), W'(0));
    chk("flush_ready", W'({m_in_ready, n_in_ready}), W'(3));
    check_counters("flush");
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Remaining vectors under a fixed out_ready pattern
    pat = 8'b1001_0110;
    fork
      for (int i = 4; i < 12; i++) send(i);
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = pat[k % 8];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_counters("vecs");

    // Asynchronous reset in the middle of a stalled stream
    out_ready = 1'b0;
    send(7);
    send(8);
    #2;
    rst_n = 1'b0;
    #2;
    check_reset_state("midrst");
    exp_m_q.delete();
    exp_n_q.delete();
    exp_acc = 0; exp_ill_m = 0; exp_ill_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Counter saturation: 18 accepts, half illegal
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) send((i % 2 == 1) ? 9 : 0);
    send(3);
    wait_drain();
    check_counters("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
